// File: rtl/nios2_debug_jtag_host_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG host.
//   jtag_state_t : host sequencing states
//   IR_*         : virtual IR codes understood by the debug slave
//   DR_WIDTH_DEF : default DR shift length (width of jdo / sr)
package nios2_debug_jtag_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } jtag_state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam int DR_WIDTH_DEF = 38;

endpackage

// File: rtl/nios2_debug_tck_gen.sv
// TCK divider for the virtual-JTAG host.
//   clk, reset_n : system clock, async active-low reset
//   run          : 0 forces TCK low and reloads the divider
//   tck          : generated TCK, low half first, each half TCK_DIV clk cycles
//   tck_rise     : high in the clk cycle whose closing edge raises tck
//   tck_fall     : high in the clk cycle whose closing edge lowers tck
module nios2_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TCK_DIV - 1);

    logic [CW-1:0] half_cnt;
    logic          half_tc;

    assign half_tc  = (half_cnt == '0);
    assign tck_rise = run & half_tc & ~tck;
    assign tck_fall = run & half_tc & tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt <= RELOAD;
            tck      <= 1'b0;
        end else if (!run) begin
            half_cnt <= RELOAD;
            tck      <= 1'b0;
        end else if (half_tc) begin
            half_cnt <= RELOAD;
            tck      <= ~tck;
        end else begin
            half_cnt <= half_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/nios2_debug_jtag_host.sv
// Virtual-JTAG initiator for the Nios II debug slave. Turns a parallel
// {IR, DR} command into the UIR/CDR/SDR/UDR/RTI strobe sequence on a
// generated TCK and returns the DR word shifted out of the slave.
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : command handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_ir_out : response handshake
//   vji_* : virtual-JTAG port toward the debug slave
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | ready for a command, TCK parked low
// UIR     | one TCK period, vji_ir_out captured on the rising edge
// CDR     | one TCK period, slave captures its DR
// SDR     | DR_WIDTH periods, one bit in/out per period, LSB first
// UDR     | one TCK period, slave updates from its DR
// RTI     | RTI_CYCLES periods of run-test-idle
// RESP    | response held on rsp_* until rsp_ready, TCK parked low
module nios2_debug_jtag_host
    import nios2_debug_jtag_host_pkg::*;
#(
    parameter int TCK_DIV    = 2,
    parameter int DR_WIDTH   = DR_WIDTH_DEF,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PW = $clog2(DR_WIDTH + RTI_CYCLES + 1);

    jtag_state_t         state;
    logic [PW-1:0]       per_cnt;
    logic                per_tc;
    logic [DR_WIDTH-1:0] shift;
    logic [DR_WIDTH:0]   shift_cat;
    logic                run;
    logic                tck_rise;
    logic                tck_fall;

    assign per_tc    = (per_cnt == '0);
    assign shift_cat = {vji_tdo, shift};
    assign run       = (state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI});

    nios2_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .tck      (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // Every period ends on tck_fall, so all state/strobe/TDI changes land on
    // the edge that lowers TCK. TDO is sampled on the edge that raises TCK,
    // before the slave reacts to that same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            per_cnt    <= '0;
            shift      <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= 2'b00;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= 2'b00;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        vji_ir_in <= cmd_ir;
                        shift     <= cmd_data;
                        per_cnt   <= '0;
                        vji_uir   <= 1'b1;
                        state     <= ST_UIR;
                    end
                end
                ST_UIR: begin
                    if (tck_rise) begin
                        rsp_ir_out <= vji_ir_out;
                    end
                    if (tck_fall) begin
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                        state   <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (tck_fall) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= shift[0];
                        per_cnt <= PW'(DR_WIDTH - 1);
                        state   <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    if (tck_rise) begin
                        shift <= shift_cat[DR_WIDTH:1];
                    end
                    if (tck_fall) begin
                        if (per_tc) begin
                            vji_sdr <= 1'b0;
                            vji_udr <= 1'b1;
                            vji_tdi <= 1'b0;
                            state   <= ST_UDR;
                        end else begin
                            // shift already advanced on this period's rising edge
                            vji_tdi <= shift[0];
                            per_cnt <= per_cnt - PW'(1);
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_fall) begin
                        vji_udr <= 1'b0;
                        vji_rti <= 1'b1;
                        per_cnt <= PW'(RTI_CYCLES - 1);
                        state   <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (tck_fall) begin
                        if (per_tc) begin
                            vji_rti   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= shift;
                            state     <= ST_RESP;
                        end else begin
                            per_cnt <= per_cnt - PW'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_debug_jtag_host.sv
// Self-checking bench for nios2_debug_jtag_host: directed vector table,
// randomized commands against a loopback slave model, backpressure and
// mid-shift reset sequences.
module tb_nios2_debug_jtag_host;
    import nios2_debug_jtag_host_pkg::*;

    localparam int DW      = 38;
    localparam int LATENCY = 1 + 2 * 2 * (3 + DW + 2);   // 173 at defaults

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ir = 2'b00;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_ir_out;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in, vji_ir_out;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    always #5 clk = ~clk;

    nios2_debug_jtag_host dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ir_out (rsp_ir_out),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_tdo    (vji_tdo),
        .vji_ir_in  (vji_ir_in),
        .vji_ir_out (vji_ir_out),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback slave: a DW-bit register that shifts TDI in on each SDR
    // TCK rising edge and presents its LSB on TDO.
    logic [DW-1:0] slave_sr = '0;
    logic          load_req = 1'b0;
    logic [DW-1:0] load_val = '0;
    logic          tck_q = 1'b0;
    logic [1:0]    ir_stat = 2'b00;

    assign vji_tdo    = slave_sr[0];
    assign vji_ir_out = vji_uir ? ir_stat : 2'b00;

    always @(posedge clk) begin
        tck_q <= vji_tck;
        if (load_req) slave_sr <= load_val;
        else if (vji_tck && !tck_q && vji_sdr) slave_sr <= {vji_tdi, slave_sr[DW-1:1]};
    end

    // Strobe monitor: rising-edge count per strobe, one-hot, order, IR stability.
    logic [4:0] stb;
    assign stb = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
    int   n_rise [5];
    int   onehot_err = 0, order_err = 0, ir_err = 0, last_idx = 0;
    logic clr = 1'b0;
    logic [1:0] cur_ir = 2'b00;

    function automatic int sidx(input logic [4:0] s);
        case (s)
            5'b00010: return 1;
            5'b00100: return 2;
            5'b01000: return 3;
            5'b10000: return 4;
            default:  return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 5; i++) n_rise[i] <= 0;
            onehot_err <= 0;
            order_err  <= 0;
            ir_err     <= 0;
            last_idx   <= 0;
        end else if (stb != 5'b0) begin
            if ($countones(stb) != 1) onehot_err <= onehot_err + 1;
            if (sidx(stb) < last_idx) order_err <= order_err + 1;
            last_idx <= sidx(stb);
            if (vji_ir_in != cur_ir) ir_err <= ir_err + 1;
            if (vji_tck && !tck_q) n_rise[sidx(stb)] <= n_rise[sidx(stb)] + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] ir, input logic [DW-1:0] data,
                          input logic [1:0] stat, input logic [DW-1:0] exp_data,
                          input int bp, input string nm);
        int hs, t, bp_err;
        logic [DW-1:0] held;
        @(negedge clk);
        clr = 1'b1; cur_ir = ir; ir_stat = stat;
        rsp_ready = (bp == 0);
        @(negedge clk);
        clr = 1'b0;
        cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            check({nm, "_accept_timeout"}, 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        hs = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 1000) begin @(negedge clk); t++; end
        check({nm, "_latency"}, 64'(cyc + 1 - hs), 64'(LATENCY));
        check({nm, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
        check({nm, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(stat));
        check({nm, "_rise_uir"}, 64'(n_rise[0]), 64'd1);
        check({nm, "_rise_cdr"}, 64'(n_rise[1]), 64'd1);
        check({nm, "_rise_sdr"}, 64'(n_rise[2]), 64'(DW));
        check({nm, "_rise_udr"}, 64'(n_rise[3]), 64'd1);
        check({nm, "_rise_rti"}, 64'(n_rise[4]), 64'd2);
        check({nm, "_strobe_errs"}, 64'(onehot_err + order_err + ir_err), 64'd0);
        if (bp > 0) begin
            held = rsp_data;
            bp_err = 0;
            cmd_valid = 1'b1;
            cmd_ir = ir ^ 2'b01;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== held || cmd_ready || vji_tck || stb != 5'b0)
                    bp_err++;
            end
            check({nm, "_backpressure_hold"}, 64'(bp_err), 64'd0);
            rsp_ready = 1'b1;
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        check({nm, "_back_to_idle"}, 64'({cmd_ready, rsp_valid, vji_tck}), 64'b100);
        check({nm, "_ir_in_held"}, 64'(vji_ir_in), 64'(ir));
    endtask

    typedef struct packed {
        logic [1:0]    ir;
        logic [DW-1:0] data;
        logic [1:0]    stat;
        logic [DW-1:0] exp_data;
        int            bp;
    } vec_t;

    vec_t          vt [4];
    logic [DW-1:0] model_word;
    int            err, t;

    initial begin
        vt[0] = '{IR_BREAK,    38'h2A_5A5A_5A5A, 2'b11, 38'h00_0000_0000, 0};
        vt[1] = '{IR_BREAK,    38'h2A_5A5A_5A5A, 2'b11, 38'h2A_5A5A_5A5A, 0};
        vt[2] = '{IR_TRACEMEM, 38'h3F_FFFF_FFFF, 2'b01, 38'h2A_5A5A_5A5A, 20};
        vt[3] = '{IR_OCIMEM,   38'h00_0000_0001, 2'b10, 38'h3F_FFFF_FFFF, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_ir_out, vji_tck, vji_tdi, vji_ir_in, stb}),
              64'b1_0_00_0_0_00_00000);
        reset_n = 1'b1;
        check("reset_rsp_data", 64'(rsp_data), 64'd0);

        err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vji_tck !== 1'b0 ||
                vji_tdi !== 1'b0 || vji_ir_in !== 2'b00 || stb !== 5'b0) err++;
        end
        check("idle_quiet_50", 64'(err), 64'd0);

        for (int i = 0; i < 4; i++)
            do_cmd(vt[i].ir, vt[i].data, vt[i].stat, vt[i].exp_data, vt[i].bp, $sformatf("vec%0d", i));

        // Random commands: the slave returns whatever word was shifted in last.
        model_word = vt[3].data;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]    r_ir, r_st;
            logic [DW-1:0] r_dat;
            r_ir  = 2'($urandom_range(3, 0));
            r_st  = 2'($urandom_range(3, 0));
            r_dat = DW'({$urandom, $urandom});
            do_cmd(r_ir, r_dat, r_st, model_word, 0, $sformatf("rnd%0d", i));
            model_word = r_dat;
        end

        // Reset in the middle of the DR shift.
        @(negedge clk);
        clr = 1'b1; cur_ir = IR_TRACECTRL; ir_stat = 2'b11;
        @(negedge clk);
        clr = 1'b0;
        cmd_ir = IR_TRACECTRL; cmd_data = 38'h15_1234_5678; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (n_rise[2] < 17 && t < 1000) begin @(negedge clk); t++; end
        check("abort_reached_bit17", 64'(n_rise[2]), 64'd17);
        #2 reset_n = 1'b0;
        #1;
        check("abort_async_outputs", 64'({cmd_ready, rsp_valid, rsp_ir_out, vji_tck, vji_tdi, vji_ir_in, stb}),
              64'b1_0_00_0_0_00_00000);
        check("abort_rsp_data", 64'(rsp_data), 64'd0);
        err = 0;
        load_req = 1'b1; load_val = 38'h0B_CAFE_F00D;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || vji_tck !== 1'b0) err++;
        end
        load_req = 1'b0;
        reset_n = 1'b1;
        check("abort_no_partial_rsp", 64'(err), 64'd0);
        do_cmd(IR_BREAK, 38'h01_0203_0405, 2'b10, 38'h0B_CAFE_F00D, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
